// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CNN tile scheduler
package cnn_pkg;
  localparam int BUFFER_WIDTH = 16;
  localparam int BUFFER_DEPTH = 8;
  localparam int BUFFER_SIZE  = BUFFER_WIDTH * BUFFER_DEPTH;
  localparam int TILE_BYTES   = BUFFER_SIZE * 4;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FINAL, DRAIN, DONE} sched_state_e;
  typedef enum logic {SRC_BUF, SRC_WB} icb_src_e;
endpackage

// File: rtl/cnn_icb_arb.sv
// cnn_icb_arb: round-robin ICB command arbiter with in-order ID FIFO and response router
module cnn_icb_arb
  import cnn_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buf_en,
  input  logic        buf_cmd_valid,
  output logic        buf_cmd_ready,
  input  logic [31:0] buf_cmd_addr,
  output logic        buf_rsp_valid,
  output logic [31:0] buf_rsp_rdata,
  input  logic        wb_cmd_valid,
  output logic        wb_cmd_ready,
  input  logic [31:0] wb_cmd_addr,
  input  logic [31:0] wb_cmd_wdata,
  output logic        wb_rsp_valid,
  output logic        nice_icb_cmd_valid,
  input  logic        nice_icb_cmd_ready,
  output logic [31:0] nice_icb_cmd_addr,
  output logic        nice_icb_cmd_read,
  output logic [31:0] nice_icb_cmd_wdata,
  input  logic        nice_icb_rsp_valid,
  input  logic [31:0] nice_icb_rsp_rdata,
  output logic        nice_icb_rsp_ready,
  output logic        fifo_empty
);
  localparam int AW = $clog2(OUTSTANDING);
  logic [OUTSTANDING-1:0] id_q;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  icb_src_e rr_last;
  logic pop, push, block, bv, grant_buf, grant_wb, head;
  assign fifo_empty = cnt == '0;
  assign pop = nice_icb_rsp_valid && !fifo_empty;
  // a response retiring this cycle frees a slot for the command presented now
  assign block = cnt == (AW+1)'(OUTSTANDING) && !pop;
  assign bv = buf_en && buf_cmd_valid;
  assign grant_buf = !block && bv && (!wb_cmd_valid || rr_last == SRC_WB);
  assign grant_wb = !block && wb_cmd_valid && !grant_buf;
  assign nice_icb_cmd_valid = grant_buf || grant_wb;
  assign nice_icb_cmd_addr = grant_buf ? buf_cmd_addr : grant_wb ? wb_cmd_addr : '0;
  assign nice_icb_cmd_read = grant_buf;
  assign nice_icb_cmd_wdata = grant_wb ? wb_cmd_wdata : '0;
  assign buf_cmd_ready = grant_buf && nice_icb_cmd_ready;
  assign wb_cmd_ready = grant_wb && nice_icb_cmd_ready;
  assign push = nice_icb_cmd_valid && nice_icb_cmd_ready;
  assign head = id_q[rp];
  assign buf_rsp_valid = pop && head;
  assign buf_rsp_rdata = buf_rsp_valid ? nice_icb_rsp_rdata : '0;
  assign wb_rsp_valid = pop && !head;
  assign nice_icb_rsp_ready = 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rr_last <= SRC_WB;
    end else begin
      if (push) begin
        id_q[wp] <= grant_buf;
        wp <= wp + 1'b1;
        rr_last <= grant_buf ? SRC_BUF : SRC_WB;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  a_rsp_on_empty: assert property (@(posedge clk) disable iff (!rst_n) !(nice_icb_rsp_valid && fifo_empty));
endmodule

// File: rtl/cnn_tile_sched.sv
// cnn_tile_sched: walks the window buffer across tiles and owns the NICE ICB channel
module cnn_tile_sched
  import cnn_pkg::*;
#(
  parameter int BUFFER_WIDTH = 16,
  parameter int BUFFER_DEPTH = 8,
  parameter int OUTSTANDING  = 4,
  parameter int TILE_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [31:0]           cfg_base_addr,
  input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  buf_req,
  output logic [31:0]           buf_req_addr,
  output logic                  buf_req_final,
  input  logic                  buf_cmd_valid,
  output logic                  buf_cmd_ready,
  input  logic [31:0]           buf_cmd_addr,
  output logic                  buf_rsp_valid,
  output logic [31:0]           buf_rsp_rdata,
  input  logic                  buf_window_finish,
  input  logic                  wb_cmd_valid,
  output logic                  wb_cmd_ready,
  input  logic [31:0]           wb_cmd_addr,
  input  logic [31:0]           wb_cmd_wdata,
  output logic                  wb_rsp_valid,
  output logic                  nice_icb_cmd_valid,
  input  logic                  nice_icb_cmd_ready,
  output logic [31:0]           nice_icb_cmd_addr,
  output logic                  nice_icb_cmd_read,
  output logic [31:0]           nice_icb_cmd_wdata,
  input  logic                  nice_icb_rsp_valid,
  input  logic [31:0]           nice_icb_rsp_rdata,
  output logic                  nice_icb_rsp_ready
);
  localparam int BUF_SIZE = BUFFER_WIDTH * BUFFER_DEPTH;
  localparam int RW = $clog2(BUF_SIZE) + 1;
  localparam logic [31:0] TILE_STRIDE = 32'(BUF_SIZE * 4);
  sched_state_e state, state_nxt;
  logic [TILE_CNT_W-1:0] tile_idx, last_idx;
  logic [31:0] base;
  logic [RW-1:0] rd_cnt;
  logic aborted_r, run_seen, fifo_empty, buf_en, abort_hit, tile_done;
  assign busy = state inside {LOAD, RUN, FINAL, DRAIN};
  assign done = state == DONE;
  assign aborted = done && aborted_r;
  assign buf_req = state == LOAD;
  assign buf_req_addr = buf_req ? base + 32'(tile_idx) * TILE_STRIDE : '0;
  assign buf_req_final = state == FINAL;
  assign abort_hit = cfg_abort && busy;
  assign buf_en = state == RUN && !aborted_r && !cfg_abort;
  // the buffer drops finish on the req edge, so the first RUN cycle still sees the stale level
  assign tile_done = run_seen && buf_window_finish && rd_cnt == RW'(BUF_SIZE);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = cfg_start ? LOAD : IDLE;
      LOAD:    state_nxt = abort_hit ? FINAL : RUN;
      RUN:     state_nxt = (abort_hit || tile_done) ? FINAL : RUN;
      FINAL:   state_nxt = (abort_hit || aborted_r || tile_idx == last_idx) ? DRAIN : LOAD;
      DRAIN:   state_nxt = (fifo_empty && !wb_cmd_valid) ? DONE : DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tile_idx <= '0;
      last_idx <= '0;
      base <= '0;
      rd_cnt <= '0;
      aborted_r <= 1'b0;
      run_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      run_seen <= state == RUN;
      rd_cnt <= buf_req ? '0 : rd_cnt + RW'(buf_rsp_valid);
      if (state == IDLE && cfg_start) begin
        base <= cfg_base_addr;
        last_idx <= cfg_num_tiles == '0 ? '0 : cfg_num_tiles - 1'b1;
        tile_idx <= '0;
        aborted_r <= 1'b0;
      end
      if (abort_hit) aborted_r <= 1'b1;
      if (state == FINAL && state_nxt == LOAD) tile_idx <= tile_idx + 1'b1;
    end
  end
  cnn_icb_arb #(.OUTSTANDING(OUTSTANDING)) u_arb (
    .clk                (clk),
    .rst_n              (rst_n),
    .buf_en             (buf_en),
    .buf_cmd_valid      (buf_cmd_valid),
    .buf_cmd_ready      (buf_cmd_ready),
    .buf_cmd_addr       (buf_cmd_addr),
    .buf_rsp_valid      (buf_rsp_valid),
    .buf_rsp_rdata      (buf_rsp_rdata),
    .wb_cmd_valid       (wb_cmd_valid),
    .wb_cmd_ready       (wb_cmd_ready),
    .wb_cmd_addr        (wb_cmd_addr),
    .wb_cmd_wdata       (wb_cmd_wdata),
    .wb_rsp_valid       (wb_rsp_valid),
    .nice_icb_cmd_valid (nice_icb_cmd_valid),
    .nice_icb_cmd_ready (nice_icb_cmd_ready),
    .nice_icb_cmd_addr  (nice_icb_cmd_addr),
    .nice_icb_cmd_read  (nice_icb_cmd_read),
    .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
    .nice_icb_rsp_valid (nice_icb_rsp_valid),
    .nice_icb_rsp_rdata (nice_icb_rsp_rdata),
    .nice_icb_rsp_ready (nice_icb_rsp_ready),
    .fifo_empty         (fifo_empty)
  );
endmodule
